// File: rtl/dmem_controller.sv
// Data-memory controller: arbitrates LSU read/write requests onto a smaller set of memory
// channels, each running its own transaction FSM, with a shared round-robin start pointer.
module dmem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter bit          WRITE_ENABLE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address  [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data     [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReadWaiting,
        StWriteWaiting,
        StReadRelaying,
        StWriteRelaying
    } state_e;

    state_e                   state_q [NUM_CHANNELS];
    logic [IdxW-1:0]          owner_q [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claim_q;
    logic [IdxW-1:0]          rr_q;

    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CONSUMERS-1:0] taken;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  grant_rd;
    logic [IdxW-1:0]          grant_idx [NUM_CHANNELS];
    logic [IdxW-1:0]          scan_idx;
    logic [IdxW-1:0]          rr_d;

    assign wr_req = WRITE_ENABLE ? consumer_write_valid : '0;

    // Idle channels pick in ascending order; a pick is hidden from later channels via `taken`.
    always_comb begin
        taken    = claim_q;
        rr_d     = rr_q;
        grant    = '0;
        grant_rd = '0;
        scan_idx = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
            if (state_q[c] == StIdle) begin
                for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                    scan_idx = IdxW'((32'(rr_q) + i) % NUM_CONSUMERS);
                    if (!grant[c] && !taken[scan_idx] &&
                        (consumer_read_valid[scan_idx] || wr_req[scan_idx])) begin
                        grant[c]        = 1'b1;
                        grant_idx[c]    = scan_idx;
                        grant_rd[c]     = consumer_read_valid[scan_idx];
                        taken[scan_idx] = 1'b1;
                        rr_d            = IdxW'((32'(scan_idx) + 1) % NUM_CONSUMERS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            claim_q              <= '0;
            rr_q                 <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_write_valid      <= '0;
            for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                consumer_read_data[k] <= '0;
            end
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]           <= StIdle;
                owner_q[c]           <= '0;
                mem_read_address[c]  <= '0;
                mem_write_address[c] <= '0;
                mem_write_data[c]    <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    StIdle: begin
                        if (grant[c]) begin
                            owner_q[c]             <= grant_idx[c];
                            claim_q[grant_idx[c]]  <= 1'b1;
                            if (grant_rd[c]) begin
                                mem_read_valid[c]   <= 1'b1;
                                mem_read_address[c] <= consumer_read_address[grant_idx[c]];
                                state_q[c]          <= StReadWaiting;
                            end else begin
                                mem_write_valid[c]   <= 1'b1;
                                mem_write_address[c] <= consumer_write_address[grant_idx[c]];
                                mem_write_data[c]    <= consumer_write_data[grant_idx[c]];
                                state_q[c]           <= StWriteWaiting;
                            end
                        end
                    end
                    StReadWaiting: begin
                        if (mem_read_ready[c]) begin
                            mem_read_valid[c]                <= 1'b0;
                            consumer_read_data[owner_q[c]]   <= mem_read_data[c];
                            consumer_read_ready[owner_q[c]]  <= 1'b1;
                            state_q[c]                       <= StReadRelaying;
                        end
                    end
                    StWriteWaiting: begin
                        if (mem_write_ready[c]) begin
                            mem_write_valid[c]               <= 1'b0;
                            consumer_write_ready[owner_q[c]] <= 1'b1;
                            state_q[c]                       <= StWriteRelaying;
                        end
                    end
                    StReadRelaying: begin
                        if (!consumer_read_valid[owner_q[c]]) begin
                            consumer_read_ready[owner_q[c]] <= 1'b0;
                            claim_q[owner_q[c]]             <= 1'b0;
                            state_q[c]                      <= StIdle;
                        end
                    end
                    StWriteRelaying: begin
                        if (!consumer_write_valid[owner_q[c]]) begin
                            consumer_write_ready[owner_q[c]] <= 1'b0;
                            claim_q[owner_q[c]]              <= 1'b0;
                            state_q[c]                       <= StIdle;
                        end
                    end
                    default: state_q[c] <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed sequences, a vector table and a
// scoreboard fed by a behavioural memory and LSU model.
module tb_dmem_controller;

    localparam int unsigned A   = 8;
    localparam int unsigned D   = 8;
    localparam int unsigned NC  = 8;
    localparam int unsigned NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [NC-1:0]  rv, rrdy, wv, wrdy;
    logic [A-1:0]   ra [NC];
    logic [D-1:0]   rdat [NC];
    logic [A-1:0]   wa [NC];
    logic [D-1:0]   wd [NC];
    logic [NCH-1:0] mrv, mrr, mwv, mwr;
    logic [A-1:0]   mra [NCH];
    logic [A-1:0]   mwa [NCH];
    logic [D-1:0]   mrd [NCH];
    logic [D-1:0]   mwd [NCH];

    dmem_controller #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(rrdy), .consumer_read_data(rdat),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(wrdy),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    // Single-channel instance for the fairness sequence
    logic [NC-1:0] f_rv, f_rrdy, f_wv, f_wrdy;
    logic [A-1:0]  f_ra [NC];
    logic [D-1:0]  f_rdat [NC];
    logic [A-1:0]  f_wa [NC];
    logic [D-1:0]  f_wd [NC];
    logic [0:0]    f_mrv, f_mrr, f_mwv, f_mwr;
    logic [A-1:0]  f_mra [1];
    logic [A-1:0]  f_mwa [1];
    logic [D-1:0]  f_mrd [1];
    logic [D-1:0]  f_mwd [1];

    dmem_controller #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .WRITE_ENABLE(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(f_rv), .consumer_read_address(f_ra),
        .consumer_read_ready(f_rrdy), .consumer_read_data(f_rdat),
        .consumer_write_valid(f_wv), .consumer_write_address(f_wa),
        .consumer_write_data(f_wd), .consumer_write_ready(f_wrdy),
        .mem_read_valid(f_mrv), .mem_read_address(f_mra),
        .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
        .mem_write_valid(f_mwv), .mem_write_address(f_mwa),
        .mem_write_data(f_mwd), .mem_write_ready(f_mwr)
    );

    typedef struct {
        int unsigned k;
        logic [D-1:0] data;
    } rd_exp_t;

    typedef struct {
        int unsigned k;
        logic [A-1:0] addr;
        bit           wr;
        logic [D-1:0] wdata;
        logic [D-1:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] mem [256];
    logic [D-1:0] ref_mem [256];
    rd_exp_t      rd_q[$];
    int unsigned  wr_q[$];
    bit           auto_mem, auto_drop, mon_en;
    int unsigned  lat;
    int unsigned  rcnt [NCH];
    int unsigned  wcnt [NCH];
    logic [NC-1:0] prev_rrdy, prev_wrdy;
    vec_t         vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor, LSU auto-release and per-channel memory model, evaluated just after each edge
    task automatic env();
        rd_exp_t e;
        int unsigned wk;
        if (mon_en) begin
            for (int unsigned k = 0; k < NC; k++) begin
                if (rrdy[k] && !prev_rrdy[k]) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected consumer=%0d actual=1 expected=0", k);
                    end else begin
                        e = rd_q.pop_front();
                        check("rd_consumer", k, e.k);
                        check("rd_data", 32'(rdat[k]), 32'(e.data));
                    end
                end
                if (wrdy[k] && !prev_wrdy[k]) begin
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected consumer=%0d actual=1 expected=0", k);
                    end else begin
                        wk = wr_q.pop_front();
                        check("wr_consumer", k, wk);
                    end
                end
            end
        end
        prev_rrdy = rrdy;
        prev_wrdy = wrdy;
        if (auto_drop) begin
            for (int unsigned k = 0; k < NC; k++) begin
                if (rrdy[k]) rv[k] = 1'b0;
                if (wrdy[k]) wv[k] = 1'b0;
            end
        end
        if (auto_mem) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (mrr[c]) mrr[c] = 1'b0;
                else if (mrv[c]) begin
                    rcnt[c]++;
                    if (rcnt[c] >= lat) begin
                        mrr[c] = 1'b1; mrd[c] = mem[mra[c]]; rcnt[c] = 0;
                    end
                end
                if (mwr[c]) mwr[c] = 1'b0;
                else if (mwv[c]) begin
                    wcnt[c]++;
                    if (wcnt[c] >= lat) begin
                        mwr[c] = 1'b1; mem[mwa[c]] = mwd[c]; wcnt[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        env();
    endtask

    task automatic wait_done(input string name, input int unsigned bound);
        int unsigned n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || rv != 0 || wv != 0 ||
                rrdy != 0 || wrdy != 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=%0d pending expected=0", name,
                     rd_q.size() + wr_q.size());
            rd_q.delete(); wr_q.delete(); rv = '0; wv = '0;
        end
        tick();
    endtask

    task automatic go_auto();
        prev_rrdy = rrdy; prev_wrdy = wrdy;
        for (int unsigned c = 0; c < NCH; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
        auto_mem = 1'b1; auto_drop = 1'b1; mon_en = 1'b1;
    endtask

    initial begin
        int unsigned grants[$];
        logic [NC-1:0] fprev;
        int unsigned diffs;

        reset = 1'b0;
        rv = '0; wv = '0; mrr = '0; mwr = '0;
        f_rv = '0; f_wv = '0; f_mrr = '0; f_mwr = '0; f_mrd[0] = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            ra[k] = '0; wa[k] = '0; wd[k] = '0; f_ra[k] = '0; f_wa[k] = '0; f_wd[k] = '0;
        end
        for (int unsigned c = 0; c < NCH; c++) mrd[c] = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = D'(i); ref_mem[i] = D'(i); end
        auto_mem = 1'b0; auto_drop = 1'b0; mon_en = 1'b0; lat = 2;
        prev_rrdy = '0; prev_wrdy = '0;

        vecs[0] = '{k: 6, addr: 8'h10, wr: 1'b0, wdata: 8'h00, exp: 8'h07};
        vecs[1] = '{k: 0, addr: 8'hFF, wr: 1'b0, wdata: 8'h00, exp: 8'hFF};
        vecs[2] = '{k: 7, addr: 8'h80, wr: 1'b1, wdata: 8'hC3, exp: 8'h00};
        vecs[3] = '{k: 7, addr: 8'h80, wr: 1'b0, wdata: 8'h00, exp: 8'hC3};
        vecs[4] = '{k: 2, addr: 8'h00, wr: 1'b0, wdata: 8'h00, exp: 8'h00};
        vecs[5] = '{k: 5, addr: 8'h33, wr: 1'b1, wdata: 8'h5A, exp: 8'h00};
        vecs[6] = '{k: 3, addr: 8'h33, wr: 1'b0, wdata: 8'h00, exp: 8'h5A};
        vecs[7] = '{k: 1, addr: 8'h7E, wr: 1'b0, wdata: 8'h00, exp: 8'h7E};

        tick(); tick();
        reset = 1'b1;
        tick();
        check("reset_mem_read_valid", 32'(mrv), 0);
        check("reset_mem_write_valid", 32'(mwv), 0);
        check("reset_read_ready", 32'(rrdy), 0);
        check("reset_write_ready", 32'(wrdy), 0);

        // Eight simultaneous reads over four channels
        go_auto();
        for (int unsigned k = 0; k < NC; k++) begin
            rv[k] = 1'b1; ra[k] = A'(k);
            rd_q.push_back('{k: k, data: D'(k)});
        end
        tick();
        check("burst_first_grants", 32'(mrv), 32'hF);
        for (int unsigned c = 0; c < NCH; c++) check("burst_grant_addr", 32'(mra[c]), c);
        wait_done("burst", 60);

        // Single read with hand-driven memory, exact latencies
        auto_mem = 1'b0; auto_drop = 1'b0; mon_en = 1'b0;
        rv[3] = 1'b1; ra[3] = 8'h05;
        tick();
        check("single_mem_valid", 32'(mrv[0]), 1);
        check("single_mem_addr", 32'(mra[0]), 32'h05);
        check("single_ready_early", 32'(rrdy[3]), 0);
        tick();
        mrr[0] = 1'b1; mrd[0] = 8'h2A;
        tick();
        check("single_ready", 32'(rrdy[3]), 1);
        check("single_data", 32'(rdat[3]), 32'h2A);
        check("single_mem_valid_drop", 32'(mrv[0]), 0);
        mrr[0] = 1'b0;
        tick();
        check("single_ready_held", 32'(rrdy[3]), 1);
        rv[3] = 1'b0;
        tick();
        check("single_ready_clear", 32'(rrdy[3]), 0);
        check("single_data_hold", 32'(rdat[3]), 32'h2A);
        tick();

        // Write with grant-time check
        go_auto();
        wv[1] = 1'b1; wa[1] = 8'h10; wd[1] = 8'h07;
        wr_q.push_back(1); ref_mem[8'h10] = 8'h07;
        tick();
        check("write_mem_valid", 32'(mwv[0]), 1);
        check("write_mem_addr", 32'(mwa[0]), 32'h10);
        check("write_mem_data", 32'(mwd[0]), 32'h07);
        wait_done("write", 30);
        check("write_mem_image", 32'(mem[8'h10]), 32'h07);

        // Vector table, one transaction each with varying memory latency
        for (int i = 0; i < 8; i++) begin
            lat = 1 + unsigned'(i % 3);
            if (vecs[i].wr) begin
                wv[vecs[i].k] = 1'b1; wa[vecs[i].k] = vecs[i].addr; wd[vecs[i].k] = vecs[i].wdata;
                wr_q.push_back(vecs[i].k); ref_mem[vecs[i].addr] = vecs[i].wdata;
            end else begin
                rv[vecs[i].k] = 1'b1; ra[vecs[i].k] = vecs[i].addr;
                rd_q.push_back('{k: vecs[i].k, data: vecs[i].exp});
            end
            wait_done("vector", 30);
        end

        // Read and write pending together: read first, then the write
        lat = 2;
        rv[4] = 1'b1; ra[4] = 8'h20; wv[4] = 1'b1; wa[4] = 8'h21; wd[4] = 8'h99;
        rd_q.push_back('{k: 4, data: 8'h20});
        wr_q.push_back(4); ref_mem[8'h21] = 8'h99;
        tick();
        check("both_read_first", 32'(mrv != 0), 1);
        check("both_no_write_yet", 32'(mwv), 0);
        wait_done("both", 40);

        // Reset during READ_WAITING with memory answering in the same cycle
        auto_mem = 1'b0; auto_drop = 1'b0; mon_en = 1'b0;
        rv[2] = 1'b1; ra[2] = 8'h09;
        tick();
        check("rst_pre_valid", 32'(mrv[0]), 1);
        tick();
        reset = 1'b0; mrr[0] = 1'b1; mrd[0] = 8'h77;
        tick();
        diffs = 0;
        for (int unsigned k = 0; k < NC; k++) if (rdat[k] != 0) diffs++;
        for (int unsigned c = 0; c < NCH; c++)
            if (mra[c] != 0 || mwa[c] != 0 || mwd[c] != 0) diffs++;
        check("rst_valids", 32'({mrv, mwv}), 0);
        check("rst_readies", 32'({rrdy, wrdy}), 0);
        check("rst_data_addr_zero", diffs, 0);
        reset = 1'b1; mrr[0] = 1'b0;
        go_auto();
        rd_q.push_back('{k: 2, data: 8'h09});
        wait_done("after_reset", 30);

        // Fairness on the single-channel instance
        f_rv[0] = 1'b1; f_rv[5] = 1'b1; fprev = '0;
        for (int n = 0; n < 80 && grants.size() < 4; n++) begin
            @(posedge clk);
            #1;
            if (f_mrr[0]) f_mrr[0] = 1'b0;
            else if (f_mrv[0]) f_mrr[0] = 1'b1;
            for (int unsigned k = 0; k < NC; k++) begin
                if (f_rrdy[k] && !fprev[k]) begin grants.push_back(k); f_rv[k] = 1'b0; end
                if (!f_rrdy[k] && fprev[k]) f_rv[k] = 1'b1;
            end
            fprev = f_rrdy;
        end
        f_rv = '0;
        check("fair_grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check("fair_grant0", grants[0], 0);
            check("fair_grant1", grants[1], 5);
            check("fair_grant2", grants[2], 0);
            check("fair_grant3", grants[3], 5);
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", diffs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
